pipe_stage_skid: RTL and testbench

- Parametrised pipeline-stage register for the CPU datapath; the successor to the plain enable-register used between stages.
- Adds a valid/ready handshake, a one-entry skid buffer for full throughput under back-pressure, flush, and a programmable reset value.
- Sits between any two pipeline stages (e.g. IF/ID, ID/EX).

---
 rtl/pipe_pkg.sv | 15 +
 rtl/dff_en_ar.sv | 22 ++
 rtl/pipe_stage_skid.sv | 112 +++++++++++
 tb/tb_pipe_stage_skid.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: handshake state encoding and common payload constants.
package pipe_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // addi x0,x0,0 -- a harmless bubble for instruction-carrying stages
  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/dff_en_ar.sv
// Enable register with asynchronous active-low reset to RESET_VAL.
// Latency 1 cycle when en is high; no handshake, the owner decides when to load.
module dff_en_ar #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, one-entry skid buffer and flush; 1-cycle latency.
// Full throughput under back-pressure; optional stall counter via PIPE_STAGE_SKID_PERF_EN.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_SKID_PERF_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  state_t           state, state_nxt;
  logic             in_xfer, out_xfer;
  logic             main_en, skid_en;
  logic [WIDTH-1:0] main_d, skid_d, skid_data;

  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Data enables only fire on real transfers, so an undriven in_data never reaches state.
  always_comb begin
    state_nxt = state;
    main_en   = 1'b0;
    skid_en   = 1'b0;
    main_d    = in_data;
    skid_d    = in_data;
    if (flush) begin
      state_nxt = ST_EMPTY;
      main_en   = 1'b1;
      skid_en   = 1'b1;
      main_d    = RESET_VAL;
      skid_d    = RESET_VAL;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_nxt = ST_BUSY;
            main_en   = 1'b1;
          end
        end
        ST_BUSY: begin
          if (in_xfer && !out_xfer) begin
            state_nxt = ST_FULL;
            skid_en   = 1'b1;
          end else if (!in_xfer && out_xfer) begin
            state_nxt = ST_EMPTY;
          end else if (in_xfer && out_xfer) begin
            main_en   = 1'b1;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            state_nxt = ST_BUSY;
            main_en   = 1'b1;
            main_d    = skid_data;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  dff_en_ar #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (main_en),
    .d     (main_d),
    .q     (out_data)
  );

  dff_en_ar #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en),
    .d     (skid_d),
    .q     (skid_data)
  );

`ifdef PIPE_STAGE_SKID_PERF_EN
  // Flush deliberately leaves the counter alone; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: expected payloads queued at issue, popped by an output monitor.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef PIPE_STAGE_SKID_PERF_EN
  logic [31:0]  stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] sb[$];

  pipe_stage_skid #(.WIDTH(W), .RESET_VAL(NOP)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_SKID_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs are stable from posedge+1 to the next posedge, so negedge sees the coming transfer.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got %h expected no output", out_data);
      end else begin
        chk("sb_data", {32'd0, out_data}, {32'd0, sb.pop_front()});
      end
    end
  end

  // Apply one cycle of stimulus; exp_acc is the hand-derived acceptance for this cycle.
  task automatic drive(input logic v, input logic [W-1:0] d, input logic ordy,
                       input logic fl, input logic exp_acc, input string tag);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    chk({tag, "_in_ready"}, {63'd0, in_ready}, {63'd0, exp_acc});
    if (v && exp_acc && !fl) sb.push_back(d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, ordy, 1'b0, 1'b1, "idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] stream [4];
    stream[0] = 32'd1; stream[1] = 32'd2; stream[2] = 32'd3; stream[3] = 32'd4;

    // Reset held with live input traffic
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_out_data",  {32'd0, out_data},  {32'd0, NOP});
    reset = 1'b1;
    drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, "first");
    chk("first_out_valid", {63'd0, out_valid}, 64'd1);
    chk("first_out_data",  {32'd0, out_data},  64'hDEADBEEF);
    idle(1'b1, 1);
    chk("first_drained", {63'd0, out_valid}, 64'd0);

    // Streaming with out_ready high: each push visible on the following cycle
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, stream[i], 1'b1, 1'b0, 1'b1, "stream");
      chk("stream_out_valid", {63'd0, out_valid}, 64'd1);
      chk("stream_out_data",  {32'd0, out_data},  {32'd0, stream[i]});
    end
    idle(1'b1, 1);
    chk("stream_drained", {63'd0, out_valid}, 64'd0);

    // Back-pressure into the skid entry
    drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b1, "bp_a");
    drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b1, "bp_b");
    chk("bp_full_out_data", {32'd0, out_data}, 64'hA);
    drive(1'b1, 32'hE, 1'b0, 1'b0, 1'b0, "bp_full");
    chk("bp_hold_out_data",  {32'd0, out_data},  64'hA);
    chk("bp_hold_out_valid", {63'd0, out_valid}, 64'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, "bp_pop_a");
    chk("bp_b_out_data", {32'd0, out_data}, 64'hB);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, "bp_pop_b");
    chk("bp_empty", {63'd0, out_valid}, 64'd0);

    // Flush while FULL with a competing input
    drive(1'b1, 32'h1A, 1'b0, 1'b0, 1'b1, "fl_a");
    drive(1'b1, 32'h1B, 1'b0, 1'b0, 1'b1, "fl_b");
    drive(1'b1, 32'hC,  1'b0, 1'b1, 1'b0, "fl_full");
    sb.delete();
    chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_out_data",  {32'd0, out_data},  {32'd0, NOP});

    // Flush in BUSY: same-edge output still consumed, same-edge input discarded
    drive(1'b1, 32'h77, 1'b0, 1'b0, 1'b1, "fl2_load");
    drive(1'b1, 32'hC,  1'b1, 1'b1, 1'b1, "fl2_busy");
    chk("fl2_out_valid", {63'd0, out_valid}, 64'd0);
    chk("fl2_sb_empty",  {32'd0, 32'(sb.size())}, 64'd0);

    // in_data undriven while in_valid is low
    in_valid = 1'b0; in_data = 'x; out_ready = 1'b1; flush = 1'b0;
    @(posedge clk); #1;
    chk("x_out_data",  {32'd0, out_data},  {32'd0, NOP});
    chk("x_out_valid", {63'd0, out_valid}, 64'd0);
    idle(1'b1, 3);

    // Asynchronous reset between edges while holding 0x55
    drive(1'b1, 32'h55, 1'b0, 1'b0, 1'b1, "ar_load");
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("ar_out_valid", {63'd0, out_valid}, 64'd0);
    chk("ar_in_ready",  {63'd0, in_ready},  64'd1);
    chk("ar_out_data",  {32'd0, out_data},  {32'd0, NOP});
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    idle(1'b1, 3);
    chk("ar_no_replay", {63'd0, out_valid}, 64'd0);

`ifdef PIPE_STAGE_SKID_PERF_EN
    chk("perf_start", {32'd0, stall_cnt}, 64'd0);
    drive(1'b1, 32'h21, 1'b0, 1'b0, 1'b1, "perf_a");
    for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b1, "perf_stall");
    chk("perf_5", {32'd0, stall_cnt}, 64'd5);
    drive(1'b0, '0, 1'b1, 1'b1, 1'b1, "perf_flush");
    drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b1, "perf_b");
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b1, "perf_stall2");
    chk("perf_8", {32'd0, stall_cnt}, 64'd8);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1, "perf_drain");
    #2 reset = 1'b0;
    #1;
    chk("perf_rst", {32'd0, stall_cnt}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(1'b1, 1);
`endif

    idle(1'b1, 2);
    chk("sb_final_empty", {32'd0, 32'(sb.size())}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
